// File: rtl/sdram_rw_scheduler.sv
// Burst-level read/write scheduler sitting above the SDRAM controller.
// Optional watchdog on the WAIT states is enabled by defining SCHED_WDOG_EN.
module sdram_rw_scheduler #(
  parameter int LVL_W       = 10,
  parameter int BURST_WORDS = 4,
  parameter int MAX_BURSTS  = 1024,
  parameter int TIMEOUT     = 255,
  localparam int CNT_W      = $clog2(MAX_BURSTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [LVL_W-1:0] wfifo_level,
  input  logic [LVL_W-1:0] rfifo_free,
  input  logic             wr_done,
  input  logic             rd_done,
  output logic             wr_trig,
  output logic             rd_trig,
  output logic             busy,
  output logic [CNT_W-1:0] stored_bursts,
  output logic             store_full,
  output logic             store_empty,
  output logic             err_timeout
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  state_t state;
  logic   last_grant;  // 1 = last burst granted was a write
  logic   wr_ok, rd_ok, grant_wr, grant_rd;
  logic   wait_done;
  logic   wd_expired;

  assign store_full  = (stored_bursts == CNT_W'(MAX_BURSTS));
  assign store_empty = (stored_bursts == '0);

  always_comb begin
    wr_ok     = enable & (wfifo_level >= LVL_W'(BURST_WORDS)) & ~store_full;
    rd_ok     = enable & ~store_empty & (rfifo_free >= LVL_W'(BURST_WORDS));
    // On a tie, hand the slot to whichever direction did not go last.
    grant_wr  = wr_ok & (~rd_ok | ~last_grant);
    grant_rd  = rd_ok & (~wr_ok | last_grant);
    wait_done = ((state == WR_WAIT) & wr_done) | ((state == RD_WAIT) & rd_done);
  end

`ifdef SCHED_WDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

  // Counter is cleared in every non-WAIT state, so it restarts on each WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == WR_WAIT) || (state == RD_WAIT)) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_expired && !wait_done)
          err_timeout <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b0;
      wr_trig       <= 1'b0;
      rd_trig       <= 1'b0;
      busy          <= 1'b0;
      stored_bursts <= '0;
    end else begin
      wr_trig <= 1'b0;
      rd_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state   <= WR_REQ;
            wr_trig <= 1'b1;
            busy    <= 1'b1;
          end else if (grant_rd) begin
            state   <= RD_REQ;
            rd_trig <= 1'b1;
            busy    <= 1'b1;
          end
        end
        WR_REQ: begin
          last_grant <= 1'b1;
          state      <= WR_WAIT;
        end
        WR_WAIT: begin
          if (wr_done) begin
            stored_bursts <= stored_bursts + 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else if (wd_expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RD_REQ: begin
          last_grant <= 1'b0;
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_done) begin
            stored_bursts <= stored_bursts - 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else if (wd_expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Directed self-checking bench for sdram_rw_scheduler (MAX_BURSTS=4, TIMEOUT=10).
module tb_sdram_rw_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] wfifo_level = '0;
  logic [9:0] rfifo_free = '0;
  logic       wr_done = 1'b0;
  logic       rd_done = 1'b0;
  logic       wr_trig, rd_trig, busy, store_full, store_empty, err_timeout;
  logic [2:0] stored_bursts;

  int vecs = 0;
  int errs = 0;

  sdram_rw_scheduler #(
    .LVL_W(10), .BURST_WORDS(4), .MAX_BURSTS(4), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wfifo_level(wfifo_level), .rfifo_free(rfifo_free),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_trig(wr_trig), .rd_trig(rd_trig), .busy(busy),
    .stored_bursts(stored_bursts), .store_full(store_full),
    .store_empty(store_empty), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a trigger pulse; both flags 0 means none appeared.
  task automatic wait_trig(output bit gw, output bit gr);
    for (int i = 0; i < 20; i++) begin
      if (wr_trig || rd_trig) break;
      tick();
    end
    gw = wr_trig;
    gr = rd_trig;
  endtask

  // Called on the trig cycle: steps into WAIT then delivers the matching done.
  task automatic finish_burst(input bit wr);
    tick();
    if (wr) wr_done = 1'b1; else rd_done = 1'b1;
    tick();
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    vecs++;
    if ({wr_trig, rd_trig, busy, store_full, store_empty, err_timeout, stored_bursts} !== {6'b000010, 3'd0}) begin
      errs++;
      $display("FAIL reset_state: got %b required %b",
               {wr_trig, rd_trig, busy, store_full, store_empty, err_timeout, stored_bursts}, {6'b000010, 3'd0});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write;
    bit gw, gr;
    enable = 1'b1; rfifo_free = 10'd0; wfifo_level = 10'd4;
    wait_trig(gw, gr);
    vecs++;
    if ({gw, gr} !== 2'b10) begin errs++; $display("FAIL single_wr_trig: got %b required 10", {gw, gr}); end
    wfifo_level = 10'd0;
    tick();
    vecs++;
    if ({wr_trig, busy} !== 2'b01) begin errs++; $display("FAIL single_wr_pulse_width: got %b required 01", {wr_trig, busy}); end
    repeat (3) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    vecs++;
    if ({stored_bursts, store_empty, busy} !== {3'd1, 2'b00}) begin
      errs++; $display("FAIL single_wr_count: got %b required %b", {stored_bursts, store_empty, busy}, {3'd1, 2'b00});
    end
  endtask

  task automatic test_alternate;
    bit gw, gr;
    logic [3:0] exp_wr = 4'b0101;  // bit i = expected direction of burst i (1 = write)
    logic [2:0] exp_cnt;
    wfifo_level = 10'd8; rfifo_free = 10'd0;
    for (int i = 0; i < 2; i++) begin
      wait_trig(gw, gr);
      vecs++;
      if ({gw, gr} !== 2'b10) begin errs++; $display("FAIL prefill_wr%0d: got %b required 10", i, {gw, gr}); end
      finish_burst(1'b1);
    end
    wfifo_level = 10'd0; rfifo_free = 10'd8;
    wait_trig(gw, gr);
    finish_burst(1'b0);
    vecs++;
    if ({gr, stored_bursts} !== {1'b1, 3'd2}) begin errs++; $display("FAIL prefill_rd: got %b required %b", {gr, stored_bursts}, {1'b1, 3'd2}); end
    wfifo_level = 10'd8; rfifo_free = 10'd8;
    exp_cnt = 3'd2;
    for (int i = 0; i < 4; i++) begin
      wait_trig(gw, gr);
      vecs++;
      if ({gw, gr} !== {exp_wr[i], ~exp_wr[i]}) begin
        errs++; $display("FAIL alternate_dir%0d: got %b required %b", i, {gw, gr}, {exp_wr[i], ~exp_wr[i]});
      end
      finish_burst(gw);
      exp_cnt = exp_wr[i] ? exp_cnt + 3'd1 : exp_cnt - 3'd1;
      vecs++;
      if (stored_bursts !== exp_cnt) begin errs++; $display("FAIL alternate_cnt%0d: got %0d required %0d", i, stored_bursts, exp_cnt); end
    end
    wfifo_level = 10'd0; rfifo_free = 10'd0;
  endtask

  task automatic test_full;
    bit gw, gr, seen;
    wfifo_level = 10'd16; rfifo_free = 10'd0;
    for (int i = 0; i < 2; i++) begin
      wait_trig(gw, gr);
      finish_burst(1'b1);
    end
    vecs++;
    if ({store_full, stored_bursts} !== {1'b1, 3'd4}) begin
      errs++; $display("FAIL full_flag: got %b required %b", {store_full, stored_bursts}, {1'b1, 3'd4});
    end
    seen = 1'b0;
    repeat (10) begin tick(); seen |= wr_trig | busy; end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL full_blocks_wr: got %b required 0", seen); end
    rfifo_free = 10'd4;
    wait_trig(gw, gr);
    vecs++;
    if ({gw, gr} !== 2'b01) begin errs++; $display("FAIL full_then_rd: got %b required 01", {gw, gr}); end
    finish_burst(1'b0);
    wfifo_level = 10'd0;
    for (int i = 0; i < 3; i++) begin
      wait_trig(gw, gr);
      finish_burst(1'b0);
    end
    vecs++;
    if ({store_empty, store_full, stored_bursts} !== {2'b10, 3'd0}) begin
      errs++; $display("FAIL drain_empty: got %b required %b", {store_empty, store_full, stored_bursts}, {2'b10, 3'd0});
    end
    rfifo_free = 10'd0;
  endtask

  task automatic test_empty_stray;
    bit seen = 1'b0;
    rfifo_free = 10'd16; wfifo_level = 10'd0;
    repeat (10) begin tick(); seen |= rd_trig | busy; end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL empty_blocks_rd: got %b required 0", seen); end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    tick();
    vecs++;
    if ({stored_bursts, store_empty, busy} !== {3'd0, 2'b10}) begin
      errs++; $display("FAIL stray_done: got %b required %b", {stored_bursts, store_empty, busy}, {3'd0, 2'b10});
    end
    rfifo_free = 10'd0;
  endtask

  task automatic test_enable;
    bit gw, gr, seen = 1'b0;
    enable = 1'b0; wfifo_level = 10'd8;
    repeat (10) begin tick(); seen |= wr_trig | busy; end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL enable_low_blocks: got %b required 0", seen); end
    enable = 1'b1;
    wait_trig(gw, gr);
    enable = 1'b0;
    repeat (6) tick();
    vecs++;
    if ({gw, busy} !== 2'b11) begin errs++; $display("FAIL enable_no_abort: got %b required 11", {gw, busy}); end
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= wr_trig | busy; end
    vecs++;
    if ({seen, stored_bursts} !== {1'b0, 3'd1}) begin
      errs++; $display("FAIL enable_finish: got %b required %b", {seen, stored_bursts}, {1'b0, 3'd1});
    end
    wfifo_level = 10'd0; enable = 1'b1;
  endtask

  task automatic test_reset_mid_burst;
    bit gw, gr;
    wfifo_level = 10'd4;
    wait_trig(gw, gr);
    wfifo_level = 10'd0;
    tick(); tick();
    vecs++;
    if ({gw, busy} !== 2'b11) begin errs++; $display("FAIL midrst_setup: got %b required 11", {gw, busy}); end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({wr_trig, rd_trig, busy, store_full, store_empty, err_timeout, stored_bursts} !== {6'b000010, 3'd0}) begin
      errs++; $display("FAIL midrst_async: got %b required %b",
               {wr_trig, rd_trig, busy, store_full, store_empty, err_timeout, stored_bursts}, {6'b000010, 3'd0});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_watchdog;
    bit gw, gr;
    wfifo_level = 10'd4;
    wait_trig(gw, gr);
    wfifo_level = 10'd0;
`ifdef SCHED_WDOG_EN
    repeat (10) tick();
    vecs++;
    if ({busy, err_timeout} !== 2'b10) begin errs++; $display("FAIL wdog_before: got %b required 10", {busy, err_timeout}); end
    tick();
    vecs++;
    if ({busy, err_timeout, stored_bursts} !== {2'b01, 3'd0}) begin
      errs++; $display("FAIL wdog_expire: got %b required %b", {busy, err_timeout, stored_bursts}, {2'b01, 3'd0});
    end
    repeat (3) tick();
    vecs++;
    if (err_timeout !== 1'b1) begin errs++; $display("FAIL wdog_sticky: got %b required 1", err_timeout); end
`else
    repeat (30) tick();
    vecs++;
    if ({gw, busy, err_timeout} !== 3'b110) begin errs++; $display("FAIL nowdog_hold: got %b required 110", {gw, busy, err_timeout}); end
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    vecs++;
    if ({busy, stored_bursts} !== {1'b0, 3'd1}) begin
      errs++; $display("FAIL nowdog_finish: got %b required %b", {busy, stored_bursts}, {1'b0, 3'd1});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_full();
    test_empty_stray();
    test_enable();
    test_reset_mid_burst();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
